// File: rtl/decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decode_sequencer
// Brief    : Recovers an LFSR keystream from a padded preamble, decrypts the
//            message held in dat_mem and strips the leading pad characters.
// Revision : 1.0
// ============================================================================
module decode_sequencer #(
   parameter int         MSG_BASE = 64,
   parameter int         MSG_LEN  = 64,
   parameter logic [7:0] PAD_CHAR = 8'h5F,
   parameter logic [5:0] SEED_KEY = 6'h1F
) (
   input  logic       clk,
   input  logic       init_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] tap_sel,
   output logic [7:0] pre_len,
   output logic [7:0] raddr,
   output logic [7:0] waddr,
   output logic       write_en,
   output logic [7:0] data_in,
   input  logic [7:0] data_out
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_SEED    = 3'd1;
   localparam logic [2:0] c_SEARCH  = 3'd2;
   localparam logic [2:0] c_DECODE  = 3'd3;
   localparam logic [2:0] c_SCAN    = 3'd4;
   localparam logic [2:0] c_COMPACT = 3'd5;
   localparam logic [2:0] c_FIN     = 3'd6;

   localparam logic [7:0] c_BASE = 8'(MSG_BASE);
   localparam logic [7:0] c_LEN  = 8'(MSG_LEN);

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [5:0] obs_q [0:6];
   logic [5:0] obs_d [0:6];
   logic [5:0] lfsr_q, lfsr_d;
   logic       rdv_q, rdv_d;
   logic       err_q, err_d;
   logic [2:0] tap_sel_q, tap_sel_d;
   logic [7:0] pre_len_q, pre_len_d;
   logic [5:0] w_tap;
   logic [5:0] w_s;
   logic       w_match;
   logic       w_cmp_act;

   function automatic logic [5:0] tap_of(input logic [2:0] idx);
      case (idx)
         3'd0:    tap_of = 6'h21;
         3'd1:    tap_of = 6'h2D;
         3'd2:    tap_of = 6'h30;
         3'd3:    tap_of = 6'h33;
         3'd4:    tap_of = 6'h36;
         3'd5:    tap_of = 6'h39;
         default: tap_of = 6'h21;
      endcase
   endfunction

   function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] tap);
      lfsr_next = {s[4:0], ^(s & tap)};
   endfunction

   // Candidate tap for this SEARCH cycle must reproduce all six observed successors.
   always_comb begin
      w_tap   = tap_of(cnt_q[2:0]);
      w_s     = obs_q[0];
      w_match = 1'b1;
      for (int k = 1; k < 7; k++) begin
         w_s = lfsr_next(w_s, w_tap);
         if (w_s != obs_q[k]) w_match = 1'b0;
      end
   end

   assign w_cmp_act = (pre_len_q != 8'd0) && (pre_len_q != c_LEN);

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q   <= c_IDLE;
         cnt_q     <= '0;
         lfsr_q    <= '0;
         rdv_q     <= 1'b0;
         err_q     <= 1'b0;
         tap_sel_q <= '0;
         pre_len_q <= '0;
         for (int j = 0; j < 7; j++) obs_q[j] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         rdv_q     <= rdv_d;
         err_q     <= err_d;
         tap_sel_q <= tap_sel_d;
         pre_len_q <= pre_len_d;
         for (int j = 0; j < 7; j++) obs_q[j] <= obs_d[j];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lfsr_d    = lfsr_q;
      rdv_d     = rdv_q;
      err_d     = err_q;
      tap_sel_d = tap_sel_q;
      pre_len_d = pre_len_q;
      obs_d     = obs_q;
      case (state_q)
         c_IDLE, c_FIN: begin
            if (start) begin
               state_d   = c_SEED;
               cnt_d     = '0;
               err_d     = 1'b0;
               tap_sel_d = '0;
               pre_len_d = '0;
            end
         end
         c_SEED: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q != 8'd0) obs_d[cnt_q[2:0] - 3'd1] = data_out[5:0] ^ SEED_KEY;
            if (cnt_q == 8'd7) begin
               state_d = c_SEARCH;
               cnt_d   = '0;
            end
         end
         c_SEARCH: begin
            if (w_match) begin
               state_d   = c_DECODE;
               tap_sel_d = cnt_q[2:0];
               lfsr_d    = obs_q[0];
               cnt_d     = '0;
            end else if (cnt_q == 8'd5) begin
               state_d = c_FIN;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         c_DECODE: begin
            if (cnt_q != 8'd0) lfsr_d = lfsr_next(lfsr_q, tap_of(tap_sel_q));
            if (cnt_q == c_LEN) begin
               state_d = c_SCAN;
               cnt_d   = '0;
               rdv_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         c_SCAN: begin
            // Reads are issued back to back; data_out always holds byte pre_len_q once rdv_q is set.
            cnt_d = cnt_q + 8'd1;
            rdv_d = 1'b1;
            if (rdv_q) begin
               if (data_out == PAD_CHAR) begin
                  pre_len_d = pre_len_q + 8'd1;
                  if (pre_len_q + 8'd1 == c_LEN) begin
                     state_d = c_COMPACT;
                     cnt_d   = '0;
                  end
               end else begin
                  state_d = c_COMPACT;
                  cnt_d   = '0;
               end
            end
         end
         c_COMPACT: begin
            if (!w_cmp_act || (cnt_q == c_LEN - pre_len_q)) begin
               state_d = c_FIN;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != c_IDLE) && (state_q != c_FIN);
      done     = (state_q == c_FIN);
      err      = err_q;
      tap_sel  = tap_sel_q;
      pre_len  = pre_len_q;
      raddr    = '0;
      waddr    = '0;
      write_en = 1'b0;
      data_in  = '0;
      case (state_q)
         c_SEED: begin
            if (cnt_q < 8'd7) raddr = c_BASE + cnt_q;
         end
         c_DECODE: begin
            if (cnt_q < c_LEN) raddr = c_BASE + cnt_q;
            if (cnt_q != 8'd0) begin
               write_en = 1'b1;
               waddr    = cnt_q - 8'd1;
               data_in  = data_out ^ {2'b00, lfsr_q};
            end
         end
         c_SCAN: raddr = cnt_q;
         c_COMPACT: begin
            if (w_cmp_act) begin
               if (cnt_q < c_LEN - pre_len_q) raddr = pre_len_q + cnt_q;
               if (cnt_q != 8'd0) begin
                  write_en = 1'b1;
                  waddr    = cnt_q - 8'd1;
                  data_in  = data_out;
               end
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_sequencer
// Brief    : Scoreboarded bench: expected writes and run results are queued
//            when an image is loaded and retired as the DUT produces them.
// Revision : 1.0
// ============================================================================
module tb_decode_sequencer;

   localparam int         MSG_BASE = 64;
   localparam int         MSG_LEN  = 64;
   localparam logic [7:0] PAD      = 8'h5F;
   localparam logic [5:0] KEY      = 6'h1F;

   logic       clk = 1'b0;
   logic       init_n;
   logic       start;
   logic       busy, done, err, write_en;
   logic [2:0] tap_sel;
   logic [7:0] pre_len, raddr, waddr, data_in, data_out;
   logic       ld_all;

   logic [7:0] mem     [0:255];
   logic [7:0] img     [0:255];
   logic [7:0] pt      [0:63];
   logic [7:0] exp_mem [0:63];

   typedef struct packed {
      logic       err;
      logic [2:0] tap;
      logic [7:0] pre;
   } res_t;

   res_t        res_q[$];
   logic [15:0] wr_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          wr_cnt      = 0;

   always #5 clk = ~clk;

   decode_sequencer #(
      .MSG_BASE(MSG_BASE), .MSG_LEN(MSG_LEN), .PAD_CHAR(PAD), .SEED_KEY(KEY)
   ) dut (
      .clk(clk), .init_n(init_n), .start(start), .busy(busy), .done(done),
      .err(err), .tap_sel(tap_sel), .pre_len(pre_len), .raddr(raddr),
      .waddr(waddr), .write_en(write_en), .data_in(data_in), .data_out(data_out)
   );

   // dat_mem model: one-cycle registered read, bulk image load between runs.
   always @(posedge clk) begin
      if (ld_all) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else if (write_en) begin
         mem[waddr] <= data_in;
      end
      data_out <= mem[raddr];
   end

   initial begin : write_monitor
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (write_en === 1'b1) begin
            wr_cnt++;
            vectors++;
            if (wr_q.size() == 0) begin
               miscompares++;
               $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", waddr, data_in);
            end else begin
               e = wr_q.pop_front();
               if ({waddr, data_in} !== e) begin
                  miscompares++;
                  $display("FAIL wr_stream: got addr=%0d data=%h, required addr=%0d data=%h",
                           waddr, data_in, e[15:8], e[7:0]);
               end
            end
         end
      end
   end

   function automatic logic [5:0] tb_tap(input int idx);
      case (idx)
         0: return 6'h21;
         1: return 6'h2D;
         2: return 6'h30;
         3: return 6'h33;
         4: return 6'h36;
         default: return 6'h39;
      endcase
   endfunction

   function automatic logic [5:0] nxt(input logic [5:0] s, input logic [5:0] t);
      return {s[4:0], ^(s & t)};
   endfunction

   function automatic int model_search();
      logic [5:0] o [0:6];
      logic [5:0] s;
      bit         ok;
      for (int j = 0; j < 7; j++) o[j] = img[MSG_BASE + j][5:0] ^ KEY;
      for (int t = 0; t < 6; t++) begin
         s  = o[0];
         ok = 1'b1;
         for (int k = 1; k < 7; k++) begin
            s = nxt(s, tb_tap(t));
            if (s != o[k]) ok = 1'b0;
         end
         if (ok) return t;
      end
      return -1;
   endfunction

   task automatic build(input int tidx, input logic [5:0] seed, input int npad, input bit allpad);
      logic [5:0] s;
      for (int k = 0; k < 64; k++)
         pt[k] = (allpad || k < npad) ? PAD : 8'($urandom_range(255, 0));
      if (!allpad) pt[npad] = 8'h41 + 8'(npad);
      for (int i = 0; i < 256; i++) img[i] = 8'(i * 7 + 3);
      s = seed;
      for (int k = 0; k < 64; k++) begin
         img[MSG_BASE + k] = pt[k] ^ {2'b00, s};
         s = nxt(s, tb_tap(tidx));
      end
   endtask

   task automatic expect_from_image();
      logic [7:0] d [0:63];
      logic [5:0] s;
      int         idx, pre;
      res_t       r;
      idx = model_search();
      for (int j = 0; j < 64; j++) exp_mem[j] = img[j];
      if (idx < 0) begin
         r.err = 1'b1; r.tap = 3'd0; r.pre = 8'd0;
         res_q.push_back(r);
         return;
      end
      s = img[MSG_BASE][5:0] ^ KEY;
      for (int k = 0; k < 64; k++) begin
         d[k] = img[MSG_BASE + k] ^ {2'b00, s};
         wr_q.push_back({8'(k), d[k]});
         exp_mem[k] = d[k];
         s = nxt(s, tb_tap(idx));
      end
      pre = 0;
      while (pre < 64 && d[pre] == PAD) pre++;
      if (pre > 0 && pre < 64) begin
         for (int j = 0; j < 64 - pre; j++) begin
            exp_mem[j] = d[pre + j];
            wr_q.push_back({8'(j), d[pre + j]});
         end
      end
      r.err = 1'b0; r.tap = 3'(idx); r.pre = 8'(pre);
      res_q.push_back(r);
   endtask

   function automatic int mem_bad();
      int n = 0;
      for (int j = 0; j < MSG_LEN; j++) if (mem[j] !== exp_mem[j]) n++;
      return n;
   endfunction

   task automatic load();
      @(negedge clk); ld_all = 1'b1;
      @(negedge clk); ld_all = 1'b0;
   endtask

   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      ok = (done === 1'b1);
   endtask

   task automatic first_write(output int cyc);
      cyc = 0;
      while (write_en !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      init_n = 1'b1; start = 1'b0; ld_all = 1'b0;
      #3 init_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, err} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: got busy/done/err=%b, required 000", {busy, done, err});
      end
      vectors++;
      if ({tap_sel, pre_len} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_result: got tap=%0d pre=%0d, required 0/0", tap_sel, pre_len);
      end
      vectors++;
      if ({write_en, raddr, waddr, data_in} !== 25'd0) begin
         miscompares++;
         $display("FAIL reset_mem_if: got we=%b ra=%h wa=%h di=%h, required all 0", write_en, raddr, waddr, data_in);
      end
      init_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_tap0();
      int cyc; bit ok; res_t r; int bad;
      build(0, 6'h0B, 10, 1'b0);
      load();
      expect_from_image();
      wr_cnt = 0;
      kick();
      first_write(cyc);
      vectors++;
      if (cyc !== 10) begin
         miscompares++;
         $display("FAIL tap0_latency: got %0d cycles to first write, required 10", cyc);
      end
      wait_done(cyc, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL tap0_timeout: got done=%b, required 1", done); end
      r = res_q.pop_front();
      vectors++;
      if ({err, tap_sel, pre_len} !== {r.err, r.tap, r.pre}) begin
         miscompares++;
         $display("FAIL tap0_result: got err=%b tap=%0d pre=%0d, required err=%b tap=%0d pre=%0d",
                  err, tap_sel, pre_len, r.err, r.tap, r.pre);
      end
      vectors++;
      if ({done, busy, err, tap_sel, pre_len} !== {1'b1, 1'b0, 1'b0, 3'd0, 8'd10}) begin
         miscompares++;
         $display("FAIL tap0_outputs: got done=%b busy=%b err=%b tap=%0d pre=%0d, required 1 0 0 0 10",
                  done, busy, err, tap_sel, pre_len);
      end
      bad = 0;
      for (int j = 0; j < 54; j++) if (mem[j] !== pt[10 + j]) bad++;
      vectors++;
      if (bad !== 0) begin miscompares++; $display("FAIL tap0_plaintext: got %0d wrong bytes, required 0", bad); end
      vectors++;
      if (wr_cnt !== 118 || wr_q.size() !== 0) begin
         miscompares++;
         $display("FAIL tap0_writes: got %0d writes (%0d pending), required 118 (0)", wr_cnt, wr_q.size());
      end
   endtask

   task automatic test_tap5();
      int cyc; bit ok; res_t r;
      for (int sd = 1; sd < 64; sd++) begin
         build(5, 6'(sd), 10, 1'b0);
         if (model_search() == 5) break;
      end
      load();
      expect_from_image();
      kick();
      first_write(cyc);
      vectors++;
      if (cyc !== 15) begin
         miscompares++;
         $display("FAIL tap5_search_len: got %0d cycles to first write, required 15", cyc);
      end
      wait_done(cyc, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL tap5_timeout: got done=%b, required 1", done); end
      r = res_q.pop_front();
      vectors++;
      if ({err, tap_sel, pre_len} !== {1'b0, 3'd5, 8'd10}) begin
         miscompares++;
         $display("FAIL tap5_result: got err=%b tap=%0d pre=%0d, required err=0 tap=5 pre=10 (model tap=%0d)",
                  err, tap_sel, pre_len, r.tap);
      end
      vectors++;
      if (mem_bad() !== 0) begin miscompares++; $display("FAIL tap5_image: got %0d wrong bytes, required 0", mem_bad()); end
   endtask

   task automatic test_no_match();
      int cyc; bit ok; res_t r;
      build(0, 6'h01, 10, 1'b0);
      do begin
         for (int j = 0; j < 7; j++) img[MSG_BASE + j] = 8'($urandom_range(255, 0));
      end while (model_search() >= 0);
      load();
      expect_from_image();
      wr_cnt = 0;
      kick();
      wait_done(cyc, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL nomatch_timeout: got done=%b, required 1", done); end
      r = res_q.pop_front();
      vectors++;
      if ({done, err} !== {1'b1, r.err} || err !== 1'b1) begin
         miscompares++;
         $display("FAIL nomatch_err: got done=%b err=%b, required done=1 err=1", done, err);
      end
      vectors++;
      if (wr_cnt !== 0) begin miscompares++; $display("FAIL nomatch_writes: got %0d writes, required 0", wr_cnt); end
      vectors++;
      if (mem_bad() !== 0) begin miscompares++; $display("FAIL nomatch_image: got %0d changed bytes, required 0", mem_bad()); end
   endtask

   task automatic test_all_pad();
      int cyc; bit ok; res_t r;
      build(1, 6'h2A, 64, 1'b1);
      load();
      expect_from_image();
      wr_cnt = 0;
      kick();
      wait_done(cyc, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL allpad_timeout: got done=%b, required 1", done); end
      r = res_q.pop_front();
      vectors++;
      if ({err, pre_len} !== {1'b0, 8'd64} || pre_len !== r.pre) begin
         miscompares++;
         $display("FAIL allpad_prelen: got err=%b pre=%0d, required err=0 pre=64", err, pre_len);
      end
      vectors++;
      if (wr_cnt !== 64) begin miscompares++; $display("FAIL allpad_writes: got %0d writes, required 64", wr_cnt); end
      vectors++;
      if (mem_bad() !== 0) begin miscompares++; $display("FAIL allpad_image: got %0d wrong bytes, required 0", mem_bad()); end
   endtask

   task automatic test_reset_mid();
      int cyc; bit ok; res_t r; int idx;
      build(2, 6'h15, 12, 1'b0);
      idx = model_search();
      load();
      expect_from_image();
      kick();
      first_write(cyc);
      repeat (19) @(negedge clk);
      vectors++;
      if (write_en !== 1'b1) begin miscompares++; $display("FAIL midrst_in_decode: got we=%b, required 1", write_en); end
      #2 init_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, err, tap_sel, pre_len} !== 14'd0) begin
         miscompares++;
         $display("FAIL midrst_status: got busy=%b done=%b err=%b tap=%0d pre=%0d, required all 0",
                  busy, done, err, tap_sel, pre_len);
      end
      vectors++;
      if ({write_en, raddr, waddr, data_in} !== 25'd0) begin
         miscompares++;
         $display("FAIL midrst_mem_if: got we=%b ra=%h wa=%h di=%h, required all 0", write_en, raddr, waddr, data_in);
      end
      wr_q.delete();
      res_q.delete();
      @(negedge clk);
      #2 init_n = 1'b1;
      expect_from_image();
      kick();
      first_write(cyc);
      vectors++;
      if (cyc !== 10 + idx) begin
         miscompares++;
         $display("FAIL midrst_restart: got %0d cycles to first write, required %0d", cyc, 10 + idx);
      end
      wait_done(cyc, ok);
      r = res_q.pop_front();
      vectors++;
      if (!ok || {err, tap_sel, pre_len} !== {r.err, r.tap, r.pre}) begin
         miscompares++;
         $display("FAIL midrst_result: got done=%b err=%b tap=%0d pre=%0d, required 1 %b %0d %0d",
                  done, err, tap_sel, pre_len, r.err, r.tap, r.pre);
      end
      vectors++;
      if (mem_bad() !== 0 || wr_q.size() !== 0) begin
         miscompares++;
         $display("FAIL midrst_image: got %0d wrong bytes %0d pending writes, required 0 0", mem_bad(), wr_q.size());
      end
   endtask

   task automatic test_start_busy();
      int cyc; bit ok; res_t r;
      int gaps [4] = '{3, 37, 42, 38};
      build(3, 6'h33, 9, 1'b0);
      load();
      expect_from_image();
      kick();
      foreach (gaps[i]) begin
         repeat (gaps[i]) @(negedge clk);
         vectors++;
         if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_pulse%0d: got busy=%b, required 1", i, busy); end
         kick();
      end
      wait_done(cyc, ok);
      r = res_q.pop_front();
      vectors++;
      if (!ok || {err, tap_sel, pre_len} !== {r.err, r.tap, r.pre}) begin
         miscompares++;
         $display("FAIL busy_result: got done=%b err=%b tap=%0d pre=%0d, required 1 %b %0d %0d",
                  done, err, tap_sel, pre_len, r.err, r.tap, r.pre);
      end
      vectors++;
      if (mem_bad() !== 0 || wr_q.size() !== 0) begin
         miscompares++;
         $display("FAIL busy_image: got %0d wrong bytes %0d pending writes, required 0 0", mem_bad(), wr_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int cyc; bit ok; res_t r;
      build(4, 6'h2C, 7, 1'b0);
      load();
      expect_from_image();
      kick();
      vectors++;
      if ({done, err, pre_len, busy} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL b2b_clear: got done=%b err=%b pre=%0d busy=%b, required 0 0 0 1", done, err, pre_len, busy);
      end
      wait_done(cyc, ok);
      r = res_q.pop_front();
      vectors++;
      if (!ok || {err, pre_len} !== 9'd7 || tap_sel !== r.tap) begin
         miscompares++;
         $display("FAIL b2b_result: got done=%b err=%b tap=%0d pre=%0d, required 1 0 %0d 7",
                  done, err, tap_sel, pre_len, r.tap);
      end
      vectors++;
      if (mem_bad() !== 0 || wr_q.size() !== 0) begin
         miscompares++;
         $display("FAIL b2b_image: got %0d wrong bytes %0d pending writes, required 0 0", mem_bad(), wr_q.size());
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_tap0();
      test_tap5();
      test_no_match();
      test_all_pad();
      test_reset_mid();
      test_start_busy();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 The block SHALL have parameter MSG_BASE, default 64, giving the data-memory address of encrypted byte 0.
REQ-002 The block SHALL have parameter MSG_LEN, default 64, giving the message length in bytes (plaintext region 0..MSG_LEN-1).
REQ-003 The block SHALL have parameter PAD_CHAR, default 8'h5F, giving the preamble pad character.
REQ-004 The block SHALL have parameter SEED_KEY, default 6'h1F, giving the XOR key used to recover LFSR states from preamble bytes.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port init_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port start, input, 1 bit: request to begin a decode run.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: high from run completion until the next accepted start.
REQ-010 The block SHALL have port err, output, 1 bit: no tap pattern matched; valid while done is high.
REQ-011 The block SHALL have port tap_sel, output, 3 bits: index of the matched tap pattern (0..5).
REQ-012 The block SHALL have port pre_len, output, 8 bits: count of leading PAD_CHAR bytes found in the decoded text.
REQ-013 The block SHALL have ports raddr (output, 8), waddr (output, 8), write_en (output, 1), data_in (output, 8) and data_out (input, 8), which drive the existing dat_mem.

Function
REQ-014 The block SHALL assume dat_mem read latency of one cycle: data_out reflects the raddr value presented in the previous cycle.
REQ-015 The FSM SHALL have states IDLE, SEED, SEARCH, DECODE, SCAN, COMPACT and FIN.
REQ-016 In IDLE, start=1 SHALL clear done, err, tap_sel and pre_len and move to SEED; start in any other state except FIN SHALL be ignored.
REQ-017 In FIN, done SHALL be held high, and start=1 SHALL be accepted exactly as in IDLE.
REQ-018 SEED SHALL read addresses MSG_BASE..MSG_BASE+6 on consecutive cycles and capture obs[j] = data_out[5:0] ^ SEED_KEY for j=0..6, taking 8 cycles.
REQ-019 The tap table SHALL be {6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39}, indexed 0..5.
REQ-020 The LFSR step SHALL be next(s) = {s[4:0], ^(s & tap)}, 6 bits wide.
REQ-021 SEARCH SHALL test one tap per cycle in ascending index; a tap matches when next^k(obs[0]) == obs[k] for all k=1..6.
REQ-022 On the first match, SEARCH SHALL latch tap_sel and go to DECODE; no later index SHALL be tested.
REQ-023 If no tap matches after 6 cycles, the block SHALL set err=1 and go to FIN with no memory write performed.
REQ-024 DECODE SHALL read MSG_BASE+k for k=0..MSG_LEN-1 on consecutive cycles.
REQ-025 One cycle after each DECODE read, the block SHALL write address k with data_in = data_out ^ {2'b00, s_k}, where s_0 = obs[0] and s_(k+1) = next(s_k); DECODE lasts MSG_LEN+1 cycles.
REQ-026 SCAN SHALL read addresses 0,1,... and increment pre_len while data_out == PAD_CHAR, stopping at the first non-pad byte or at pre_len == MSG_LEN.
REQ-027 COMPACT SHALL copy address pre_len+j to address j for j=0..MSG_LEN-1-pre_len, one read per cycle with each write one cycle after its read, then go to FIN.
REQ-028 If pre_len == 0 or pre_len == MSG_LEN, COMPACT SHALL perform no writes.
REQ-029 write_en SHALL be high only in DECODE and COMPACT write cycles, and SHALL never be high in the same cycle as a write to an address >= MSG_BASE.
REQ-030 busy SHALL equal (state != IDLE && state != FIN).
REQ-031 raddr, waddr and data_in SHALL be don't-care whenever write_en=0, except that raddr is valid in read cycles.
REQ-032 All address arithmetic SHALL be 8-bit unsigned with no wrap beyond 8'hFF.

Reset
REQ-033 When init_n=0, the block SHALL immediately (asynchronously) enter IDLE and drive busy=0, done=0, err=0, tap_sel=0, pre_len=0, write_en=0, raddr=0, waddr=0 and data_in=0.
REQ-034 Reset asserted mid-run SHALL abort the run, leave memory contents partially written, and require a new start to resume operation.
REQ-035 After init_n rises, the first start SHALL be accepted at the next clock edge.

Verification
REQ-036 Message encrypted with tap 6'h21 and 10 leading 8'h5F -> done=1, err=0, tap_sel=0, pre_len=10, mem[0..53] = plaintext following the pad.
REQ-037 Same stimulus with tap 6'h39 -> tap_sel=5, and SEARCH occupies exactly 6 cycles.
REQ-038 Preamble bytes MSG_BASE..+6 set to random non-LFSR values -> err=1, done=1, write_en never asserted.
REQ-039 All 64 decoded bytes equal 8'h5F -> pre_len=64, and no COMPACT writes occur.
REQ-040 init_n pulsed low during DECODE cycle 20 -> write_en=0 immediately, all outputs at reset values; a following start completes a normal run.
REQ-041 start pulsed while busy=1 -> ignored, and the run result is identical to one with no extra start.
